// File: rtl/nibble_serial_addsub.sv
// Nibble-serial add/subtract: WIDTH-bit operands summed one 4-bit slice per clock, LSB first.
// Optional saturation on signed overflow is enabled by defining NIBBLE_SERIAL_ADDSUB_SAT_EN.
module nibble_serial_addsub #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);
   localparam int N  = WIDTH / 4;
   localparam int IW = (N > 2) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic [WIDTH-1:0] final_res;
   logic             cin;
   logic [IW-1:0]    idx;
   logic [3:0]       a_nib;
   logic [3:0]       b_nib;
   logic [3:0]       s_nib;
   logic             c_out;
   logic             c_msb;
   logic             final_ovf;
   logic             last;
   logic             accept;
   logic             handoff;

   function automatic logic [4:0] nib_add(input logic [3:0] x, input logic [3:0] y, input logic ci);
      nib_add = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
   endfunction

   assign in_ready = (state == IDLE) && !rst;
   assign accept   = in_valid && in_ready;
   assign handoff  = out_valid && out_ready;
   assign last     = (idx == IW'(N - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = RUN;  else state_next = IDLE;
         RUN:  if (last)   state_next = DONE; else state_next = RUN;
         DONE: if (handoff) state_next = IDLE; else state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   // Current nibble slice; carry into the slice MSB is recovered from the sum bit for overflow
   always_comb begin
      a_nib          = a_reg[{idx, 2'b00} +: 4];
      b_nib          = b_reg[{idx, 2'b00} +: 4];
      {c_out, s_nib} = nib_add(a_nib, b_nib, cin);
      c_msb          = a_nib[3] ^ b_nib[3] ^ s_nib[3];
      final_ovf      = c_msb ^ c_out;
      acc_next       = acc;
      acc_next[{idx, 2'b00} +: 4] = s_nib;
      final_res      = acc_next;
`ifdef NIBBLE_SERIAL_ADDSUB_SAT_EN
      if (final_ovf) begin
         final_res = a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         final_res = acc_next;
      end
`endif
   end

   // Operand capture, nibble sequencing and registered result/flags
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg     <= {WIDTH{1'b0}};
         b_reg     <= {WIDTH{1'b0}};
         acc       <= {WIDTH{1'b0}};
         cin       <= 1'b0;
         idx       <= {IW{1'b0}};
         result    <= {WIDTH{1'b0}};
         carry     <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_reg <= a;
                  b_reg <= b ^ {WIDTH{sub}};
                  cin   <= sub;
                  idx   <= {IW{1'b0}};
                  acc   <= {WIDTH{1'b0}};
               end
            end
            RUN: begin
               acc <= acc_next;
               cin <= c_out;
               idx <= idx + IW'(1'b1);
               if (last) begin
                  idx       <= {IW{1'b0}};
                  result    <= final_res;
                  carry     <= c_out;
                  overflow  <= final_ovf;
                  zero      <= (final_res == {WIDTH{1'b0}});
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (handoff) begin
                  out_valid <= 1'b0;
               end
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Scoreboard bench for nibble_serial_addsub: driver pushes model results, negedge monitor pops and compares.
module tb_nibble_serial_addsub;
   localparam int W = 16;
   localparam int N = W / 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carry;
   logic         overflow;
   logic         zero;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [W-1:0] res;
      logic         c;
      logic         v;
      logic         z;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   nibble_serial_addsub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .overflow  (overflow),
      .zero      (zero)
   );

   function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endfunction

   // Reference: plain integer arithmetic on the unsigned and signed readings of the operands
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      exp_t e;
      int ux = x;
      int uy = y;
      int sx = $signed(x);
      int sy = $signed(y);
      int ures = s ? (ux - uy) : (ux + uy);
      int sres = s ? (sx - sy) : (sx + sy);
      e.res = ures[W-1:0];
      e.c   = s ? (ux >= uy) : (ures >= (1 << W));
      e.v   = (sres > ((1 << (W-1)) - 1)) || (sres < -(1 << (W-1)));
`ifdef NIBBLE_SERIAL_ADDSUB_SAT_EN
      if (e.v) e.res = x[W-1] ? 16'h8000 : 16'h7FFF;
`endif
      e.z   = (e.res == 16'h0000);
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%h expected=none", result);
         end else begin
            e = sb.pop_front();
            chk("result",   result,   e.res);
            chk("carry",    carry,    e.c);
            chk("overflow", overflow, e.v);
            chk("zero",     zero,     e.z);
         end
      end
   end

   task automatic wait_ready();
      int k = 0;
      while (!in_ready && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      chk("in_ready_idle", in_ready, 1'b1);
   endtask

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts, input int hold);
      logic [W-1:0] r0;
      logic [2:0]   f0;
      wait_ready();
      out_ready = (hold == 0);
      a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
      @(posedge clk); #1;
      sb.push_back(model(ta, tb_v, ts));
      chk("in_ready_after_accept", in_ready, 1'b0);
      chk("out_valid_after_accept", out_valid, 1'b0);
      for (int i = 1; i <= N; i++) begin
         in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
         @(posedge clk); #1;
         chk("out_valid_latency", out_valid, (i == N));
         chk("in_ready_busy", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      r0 = result;
      f0 = {carry, overflow, zero};
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
         @(posedge clk); #1;
         chk("hold_result", result, r0);
         chk("hold_flags", {carry, overflow, zero}, f0);
         chk("hold_out_valid", out_valid, 1'b1);
         chk("hold_in_ready", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("out_valid_after_handshake", out_valid, 1'b0);
      chk("in_ready_after_handshake", in_ready, 1'b1);
   endtask

   task automatic abort_op();
      int seen = 0;
      wait_ready();
      out_ready = 1'b1;
      a = 16'h00AA; b = 16'h0055; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("in_ready_in_reset", in_ready, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("abort_result", result, 16'h0000);
      chk("abort_flags", {carry, overflow, zero}, 3'b000);
      chk("abort_out_valid", out_valid, 1'b0);
      chk("abort_in_ready", in_ready, 1'b1);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("abort_no_out_valid", seen, 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 16'h0000; b = 16'h0000; sub = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_result", result, 16'h0000);
      chk("reset_flags", {carry, overflow, zero}, 3'b000);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_in_ready", in_ready, 1'b0);
      rst = 1'b0;
      #1;
      chk("in_ready_after_reset", in_ready, 1'b1);

      run_op(16'h1234, 16'h0FFF, 1'b0, 0);
      run_op(16'h0005, 16'h0005, 1'b1, 0);
      run_op(16'h0000, 16'h0001, 1'b1, 0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 0);
      run_op(16'h7FFF, 16'h0001, 1'b0, 0);
      run_op(16'h8000, 16'h0001, 1'b1, 0);
      abort_op();
      run_op(16'h0001, 16'h0002, 1'b0, 0);
      run_op(16'hA5C3, 16'h1F0E, 1'b0, 5);
      for (int i = 0; i < 30; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      end
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
